// File: rtl/ray_pkg.sv
// Shared ray types and the component-wise vector add used by every accumulator.
// RAY_GEN_SAT_EN selects saturating adds; otherwise adds wrap (two's complement).
package ray_pkg;

  localparam int RAY_W = 16;

  typedef logic signed [RAY_W-1:0] comp_t;

  typedef struct packed {
    comp_t x;
    comp_t y;
    comp_t z;
  } vec3_t;

  function automatic comp_t cadd(input comp_t a, input comp_t b);
`ifdef RAY_GEN_SAT_EN
    logic [RAY_W:0] s;
    comp_t          res;
    s = {a[RAY_W-1], a} + {b[RAY_W-1], b};
    // Overflow shows up as the two top bits of the extended sum disagreeing.
    if (s[RAY_W] != s[RAY_W-1])
      res = s[RAY_W] ? {1'b1, {(RAY_W-1){1'b0}}} : {1'b0, {(RAY_W-1){1'b1}}};
    else
      res = s[RAY_W-1:0];
    return res;
`else
    return a + b;
`endif
  endfunction

  function automatic vec3_t vadd(input vec3_t a, input vec3_t b);
    vec3_t res;
    res.x = cadd(a.x, b.x);
    res.y = cadd(a.y, b.y);
    res.z = cadd(a.z, b.z);
    return res;
  endfunction

endpackage

// File: rtl/vec3_acc.sv
// One vec3 register, load has priority over accumulate; updates on the edge that samples the control.
// No backpressure; RAY_GEN_SAT_EN (via vadd) selects saturating accumulate.
module vec3_acc
  import ray_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  vec3_t load_val,
  input  logic  add,
  input  vec3_t add_val,
  output vec3_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (add) begin
      q <= vadd(q, add_val);
    end
  end

endmodule

// File: rtl/ray_gen.sv
// Per-pixel ray direction generator: incremental adds, 1-cycle latency, 1 ray/clk, no backpressure
// (pix_adv past end of line is ignored). RAY_GEN_SAT_EN selects saturating accumulator adds.
module ray_gen
  import ray_pkg::*;
#(
  parameter int W        = 16,
  parameter int H_PIXELS = 640,
  parameter int XW       = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_start,
  input  logic                line_start,
  input  logic                pix_adv,
  input  logic signed [W-1:0] cx,
  input  logic signed [W-1:0] cy,
  input  logic signed [W-1:0] cz,
  input  logic signed [W-1:0] ux,
  input  logic signed [W-1:0] uy,
  input  logic signed [W-1:0] uz,
  input  logic signed [W-1:0] vx,
  input  logic signed [W-1:0] vy,
  input  logic signed [W-1:0] vz,
  output logic signed [W-1:0] rx,
  output logic signed [W-1:0] ry,
  output logic signed [W-1:0] rz,
  output logic                start,
  output logic [XW-1:0]       ray_x,
  output logic                line_done
);

  localparam logic [XW-1:0] LAST_X = XW'(H_PIXELS - 1);

  vec3_t c_in, u_in, v_in;
  vec3_t u_q, v_q;
  vec3_t l_q, r_q;
  vec3_t l_init, r_load_val;
  logic  do_frame, do_line, do_pix;
  logic  [XW-1:0] next_x;

  assign c_in = '{x: cx, y: cy, z: cz};
  assign u_in = '{x: ux, y: uy, z: uz};
  assign v_in = '{x: vx, y: vy, z: vz};

  // frame_start > line_start > pix_adv; advances past the last pixel are dropped.
  always_comb begin
    do_frame   = frame_start;
    do_line    = line_start & ~frame_start;
    do_pix     = pix_adv & ~frame_start & ~line_start & ~line_done;
    l_init     = vadd(c_in, v_in);
    r_load_val = do_frame ? c_in : l_q;
    next_x     = ray_x + XW'(1);
  end

  // The corner ray goes straight into R and into L's seed, so only the step vectors are shadowed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_q <= '0;
      v_q <= '0;
    end else if (do_frame) begin
      u_q <= u_in;
      v_q <= v_in;
    end
  end

  vec3_acc u_line_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (do_frame),
    .load_val (l_init),
    .add      (do_line),
    .add_val  (v_q),
    .q        (l_q)
  );

  vec3_acc u_ray_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (do_frame | do_line),
    .load_val (r_load_val),
    .add      (do_pix),
    .add_val  (u_q),
    .q        (r_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ray_x     <= '0;
      line_done <= 1'b0;
      start     <= 1'b0;
    end else begin
      start <= do_frame | do_line | do_pix;
      if (do_frame | do_line) begin
        ray_x     <= '0;
        line_done <= 1'b0;
      end else if (do_pix) begin
        ray_x     <= next_x;
        line_done <= (next_x == LAST_X);
      end
    end
  end

  assign rx = r_q.x;
  assign ry = r_q.y;
  assign rz = r_q.z;

endmodule

// File: tb/tb_ray_gen.sv
// Directed bench for ray_gen; expected rays are hand-derived from the camera vectors.
// Saturation expectations follow RAY_GEN_SAT_EN.
module tb_ray_gen;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               frame_start, line_start, pix_adv;
  logic signed [15:0] cx, cy, cz, ux, uy, uz, vx, vy, vz;
  logic signed [15:0] rx, ry, rz;
  logic               start;
  logic [9:0]         ray_x;
  logic               line_done;

  int vectors     = 0;
  int miscompares = 0;

  logic signed [15:0] ex, ey, ez;

  always #5 clk = ~clk;

  ray_gen #(.W(16), .H_PIXELS(640), .XW(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .line_start  (line_start),
    .pix_adv     (pix_adv),
    .cx          (cx),
    .cy          (cy),
    .cz          (cz),
    .ux          (ux),
    .uy          (uy),
    .uz          (uz),
    .vx          (vx),
    .vy          (vy),
    .vz          (vz),
    .rx          (rx),
    .ry          (ry),
    .rz          (rz),
    .start       (start),
    .ray_x       (ray_x),
    .line_done   (line_done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_camera;
    cx = -16'sd320; cy = -16'sd240; cz = 16'sd512;
    ux = 16'sd1;    uy = 16'sd0;    uz = 16'sd0;
    vx = 16'sd0;    vy = 16'sd1;    vz = 16'sd0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    tick;
    vectors++;
    if ({rx, ry, rz, start, ray_x, line_done} !== 60'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got r=(%0d,%0d,%0d) start=%b x=%0d done=%b want all zero",
               rx, ry, rz, start, ray_x, line_done);
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_frame_start;
    set_camera;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    ex = -16'sd320; ey = -16'sd240; ez = 16'sd512;
    vectors++;
    if ({rx, ry, rz} !== {ex, ey, ez}) begin
      miscompares++;
      $display("FAIL fs_ray: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", rx, ry, rz, ex, ey, ez);
    end
    vectors++;
    if ({start, ray_x, line_done} !== {1'b1, 10'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL fs_ctrl: got start=%b x=%0d done=%b want start=1 x=0 done=0", start, ray_x, line_done);
    end
    tick;
    vectors++;
    if (start !== 1'b0) begin
      miscompares++;
      $display("FAIL fs_start_width: got start=%b want 0", start);
    end
    vectors++;
    if ({rx, ry, rz} !== {ex, ey, ez}) begin
      miscompares++;
      $display("FAIL fs_ray_hold: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", rx, ry, rz, ex, ey, ez);
    end
  endtask

  task automatic test_back_to_back;
    pix_adv = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick;
      ex = 16'(-320 + i);
      vectors++;
      if ({rx, ry, rz} !== {ex, -16'sd240, 16'sd512}) begin
        miscompares++;
        $display("FAIL b2b_ray%0d: got (%0d,%0d,%0d) want (%0d,-240,512)", i, rx, ry, rz, ex);
      end
      vectors++;
      if ({start, ray_x} !== {1'b1, 10'(i)}) begin
        miscompares++;
        $display("FAIL b2b_ctrl%0d: got start=%b x=%0d want start=1 x=%0d", i, start, ray_x, i);
      end
    end
    pix_adv = 1'b0;
    tick;
    vectors++;
    if ({start, ray_x, rx} !== {1'b0, 10'd3, -16'sd317}) begin
      miscompares++;
      $display("FAIL b2b_idle: got start=%b x=%0d rx=%0d want start=0 x=3 rx=-317", start, ray_x, rx);
    end
  endtask

  task automatic test_line_end;
    pix_adv = 1'b1;
    repeat (635) tick;
    pix_adv = 1'b0;
    vectors++;
    if ({ray_x, line_done, rx} !== {10'd638, 1'b0, 16'sd318}) begin
      miscompares++;
      $display("FAIL eol_638: got x=%0d done=%b rx=%0d want x=638 done=0 rx=318", ray_x, line_done, rx);
    end
    tick;
    pix_adv = 1'b1;
    tick;
    pix_adv = 1'b0;
    vectors++;
    if ({ray_x, line_done, rx, start} !== {10'd639, 1'b1, 16'sd319, 1'b1}) begin
      miscompares++;
      $display("FAIL eol_639: got x=%0d done=%b rx=%0d start=%b want x=639 done=1 rx=319 start=1",
               ray_x, line_done, rx, start);
    end
    pix_adv = 1'b1;
    tick;
    pix_adv = 1'b0;
    vectors++;
    if ({ray_x, line_done, rx, start} !== {10'd639, 1'b1, 16'sd319, 1'b0}) begin
      miscompares++;
      $display("FAIL eol_ignore: got x=%0d done=%b rx=%0d start=%b want x=639 done=1 rx=319 start=0",
               ray_x, line_done, rx, start);
    end
    line_start = 1'b1;
    tick;
    line_start = 1'b0;
    ex = -16'sd320; ey = -16'sd239; ez = 16'sd512;
    vectors++;
    if ({rx, ry, rz, start, ray_x, line_done} !== {ex, ey, ez, 1'b1, 10'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL line_start: got r=(%0d,%0d,%0d) start=%b x=%0d done=%b want r=(-320,-239,512) start=1 x=0 done=0",
               rx, ry, rz, start, ray_x, line_done);
    end
  endtask

  task automatic test_priority;
    frame_start = 1'b1;
    pix_adv     = 1'b1;
    tick;
    frame_start = 1'b0;
    pix_adv     = 1'b0;
    vectors++;
    if ({rx, ry, rz, start, ray_x} !== {-16'sd320, -16'sd240, 16'sd512, 1'b1, 10'd0}) begin
      miscompares++;
      $display("FAIL prio_fs_pix: got r=(%0d,%0d,%0d) start=%b x=%0d want r=(-320,-240,512) start=1 x=0",
               rx, ry, rz, start, ray_x);
    end
    ux      = 16'sd5;
    pix_adv = 1'b1;
    tick;
    pix_adv = 1'b0;
    vectors++;
    if ({rx, ray_x} !== {-16'sd319, 10'd1}) begin
      miscompares++;
      $display("FAIL midframe_u: got rx=%0d x=%0d want rx=-319 x=1", rx, ray_x);
    end
    line_start = 1'b1;
    pix_adv    = 1'b1;
    tick;
    line_start = 1'b0;
    pix_adv    = 1'b0;
    vectors++;
    if ({rx, ry, ray_x} !== {-16'sd320, -16'sd239, 10'd0}) begin
      miscompares++;
      $display("FAIL prio_ls_pix: got rx=%0d ry=%0d x=%0d want rx=-320 ry=-239 x=0", rx, ry, ray_x);
    end
    line_start = 1'b1;
    tick;
    line_start = 1'b0;
    vectors++;
    if ({rx, ry, rz} !== {-16'sd320, -16'sd238, 16'sd512}) begin
      miscompares++;
      $display("FAIL second_line: got (%0d,%0d,%0d) want (-320,-238,512)", rx, ry, rz);
    end
    ux = 16'sd1;
  endtask

  task automatic test_saturate;
    cx = -16'sd32766; cy = -16'sd1; cz = 16'sd0;
    ux = 16'sd32767;  uy = 16'sd0;  uz = 16'sd0;
    vx = 16'sd0;      vy = 16'h8000; vz = 16'sd0;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    vectors++;
    if (rx !== -16'sd32766) begin
      miscompares++;
      $display("FAIL sat_corner: got rx=%0d want -32766", rx);
    end
    pix_adv = 1'b1;
    tick;
    pix_adv = 1'b0;
    vectors++;
    if (rx !== 16'sd1) begin
      miscompares++;
      $display("FAIL sat_x1: got rx=%0d want 1", rx);
    end
    pix_adv = 1'b1;
    tick;
    pix_adv = 1'b0;
`ifdef RAY_GEN_SAT_EN
    ex = 16'sd32767;
    ey = 16'h8000;
`else
    ex = 16'h8000;
    ey = 16'sd32767;
`endif
    vectors++;
    if (rx !== ex) begin
      miscompares++;
      $display("FAIL ovf_pixel: got rx=%0d want %0d", rx, ex);
    end
    line_start = 1'b1;
    tick;
    line_start = 1'b0;
    vectors++;
    if ({rx, ry} !== {-16'sd32766, ey}) begin
      miscompares++;
      $display("FAIL ovf_line: got rx=%0d ry=%0d want rx=-32766 ry=%0d", rx, ry, ey);
    end
  endtask

  task automatic test_reset_mid;
    set_camera;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    pix_adv = 1'b1;
    tick;
    pix_adv = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({rx, ry, rz, start, ray_x, line_done} !== 60'd0) begin
      miscompares++;
      $display("FAIL rst_async: got r=(%0d,%0d,%0d) start=%b x=%0d done=%b want all zero",
               rx, ry, rz, start, ray_x, line_done);
    end
    tick;
    vectors++;
    if ({rx, ry, rz, start, ray_x, line_done} !== 60'd0) begin
      miscompares++;
      $display("FAIL rst_held: got r=(%0d,%0d,%0d) start=%b x=%0d done=%b want all zero",
               rx, ry, rz, start, ray_x, line_done);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      vectors++;
      if ({start, rx, ry, rz} !== 49'd0) begin
        miscompares++;
        $display("FAIL rst_quiet%0d: got start=%b r=(%0d,%0d,%0d) want start=0 r=0", i, start, rx, ry, rz);
      end
    end
    pix_adv = 1'b1;
    tick;
    pix_adv = 1'b0;
    vectors++;
    if ({start, ray_x, rx, ry, rz} !== {1'b1, 10'd1, 48'd0}) begin
      miscompares++;
      $display("FAIL rst_zero_state: got start=%b x=%0d r=(%0d,%0d,%0d) want start=1 x=1 r=0",
               start, ray_x, rx, ry, rz);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    frame_start = 1'b0;
    line_start  = 1'b0;
    pix_adv     = 1'b0;
    set_camera;
    test_reset;
    test_frame_start;
    test_back_to_back;
    test_line_end;
    test_priority;
    test_saturate;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
